// File: rtl/ex_case_chk.sv
// Receive-side frame checker: hunts for the W0/W2 framed pattern, confirms
// alignment over LOCK_FRAMES clean frames, then counts violations while locked.
module ex_case_chk #(
   parameter int          PERIOD      = 8,
   parameter logic [7:0]  W0          = 8'd7,
   parameter logic [7:0]  W2          = 8'd5,
   parameter int          LOCK_FRAMES = 2,
   parameter int          LOSS_FRAMES = 2,
   parameter int          CNT_W       = 16,
   localparam int         SW          = $clog2(PERIOD)
) (
   input  logic             sclk,
   input  logic             rst_n,
   input  logic             i_dv,
   input  logic [7:0]       i_data,
   output logic             o_locked,
   output logic             o_err,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [CNT_W-1:0] o_frame_cnt,
   output logic [SW-1:0]    o_slot
);

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   localparam logic [SW-1:0] LAST   = SW'(PERIOD - 1);
   localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);
   localparam logic [3:0]    LOSS_N = 4'(LOSS_FRAMES);

   state_t           state, state_nx;
   logic [SW-1:0]    slot, slot_nx;
   logic [3:0]       good, good_nx;
   logic [3:0]       bad, bad_nx;
   logic             frame_bad, frame_bad_nx;
   logic             err_nx;
   logic [CNT_W-1:0] err_cnt_nx, frame_cnt_nx;
   logic             mismatch, hit_w0, frame_end, fb_now;

   // Expected sample for the current slot; idle slots only care about dv.
   always_comb begin
      if (slot == '0)
         mismatch = !(i_dv && (i_data == W0));
      else if (slot == SW'(2))
         mismatch = !(i_dv && (i_data == W2));
      else
         mismatch = i_dv;
   end

   assign hit_w0    = i_dv && (i_data == W0);
   assign frame_end = (slot == LAST);
   assign fb_now    = frame_bad | mismatch;

   always_comb begin
      state_nx     = state;
      slot_nx      = slot;
      good_nx      = good;
      bad_nx       = bad;
      frame_bad_nx = frame_bad;
      err_nx       = 1'b0;
      err_cnt_nx   = o_err_cnt;
      frame_cnt_nx = o_frame_cnt;
      case (state)
         HUNT: begin
            if (hit_w0) begin
               state_nx     = SYNC;
               slot_nx      = SW'(1);
               good_nx      = '0;
               frame_bad_nx = 1'b0;
            end
         end
         SYNC: begin
            // A mismatch aborts without re-using this sample as a hunt candidate.
            if (mismatch) begin
               state_nx = HUNT;
               slot_nx  = '0;
               good_nx  = '0;
            end else begin
               slot_nx = slot + SW'(1);
               if (frame_end) begin
                  if (good + 4'd1 == LOCK_N) begin
                     state_nx     = LOCKED;
                     good_nx      = '0;
                     bad_nx       = '0;
                     frame_bad_nx = 1'b0;
                  end else begin
                     good_nx = good + 4'd1;
                  end
               end
            end
         end
         LOCKED: begin
            slot_nx = slot + SW'(1);
            if (mismatch) begin
               err_nx = 1'b1;
               if (o_err_cnt != '1)
                  err_cnt_nx = o_err_cnt + CNT_W'(1);
            end
            if (frame_end) begin
               frame_bad_nx = 1'b0;
               if (!fb_now) begin
                  frame_cnt_nx = o_frame_cnt + CNT_W'(1);
                  bad_nx       = '0;
               end else begin
                  bad_nx = bad + 4'd1;
                  if (bad + 4'd1 == LOSS_N) begin
                     state_nx = HUNT;
                     slot_nx  = '0;
                  end
               end
            end else begin
               frame_bad_nx = fb_now;
            end
         end
         default: begin
            state_nx = HUNT;
            slot_nx  = '0;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         slot        <= '0;
         good        <= '0;
         bad         <= '0;
         frame_bad   <= 1'b0;
         o_err       <= 1'b0;
         o_err_cnt   <= '0;
         o_frame_cnt <= '0;
      end else begin
         state       <= state_nx;
         slot        <= slot_nx;
         good        <= good_nx;
         bad         <= bad_nx;
         frame_bad   <= frame_bad_nx;
         o_err       <= err_nx;
         o_err_cnt   <= err_cnt_nx;
         o_frame_cnt <= frame_cnt_nx;
      end
   end

   assign o_locked = (state == LOCKED);
   assign o_slot   = slot;

endmodule

// File: tb/tb_ex_case_chk.sv
// Bench for ex_case_chk: stream stimulus with injected faults, scoreboard
// against a cycle-phase reference model, plus directed milestone checks.
module tb_ex_case_chk;
   localparam int         P     = 8;
   localparam int         CW    = 4;
   localparam int         LOCKF = 2;
   localparam int         LOSSF = 2;
   localparam logic [7:0] W0    = 8'd7;
   localparam logic [7:0] W2    = 8'd5;

   logic          sclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_dv = 1'b0;
   logic [7:0]    i_data = 8'h00;
   logic          o_locked, o_err;
   logic [CW-1:0] o_err_cnt, o_frame_cnt;
   logic [2:0]    o_slot;

   ex_case_chk #(.PERIOD(P), .W0(W0), .W2(W2), .LOCK_FRAMES(LOCKF),
                 .LOSS_FRAMES(LOSSF), .CNT_W(CW)) dut (
      .sclk(sclk), .rst_n(rst_n), .i_dv(i_dv), .i_data(i_data),
      .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt),
      .o_frame_cnt(o_frame_cnt), .o_slot(o_slot));

   always #5 sclk = ~sclk;

   typedef struct packed {
      logic          locked;
      logic          err;
      logic [CW-1:0] ec;
      logic [CW-1:0] fc;
      logic [2:0]    slot;
   } obs_t;

   obs_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   // Model keeps an absolute cycle count and the cycle where slot 0 was found.
   int m_mode;   // 0 searching, 1 confirming, 2 locked
   int cyc = 0;
   int base = 0;
   int clean, loss, errs, frames;
   bit dirty;

   function automatic bit slot_ok(int ph, logic dv, logic [7:0] d);
      if (ph == 0) return dv && (d == W0);
      if (ph == 2) return dv && (d == W2);
      return !dv;
   endfunction

   function automatic void model_reset();
      m_mode = 0; clean = 0; loss = 0; errs = 0; frames = 0; dirty = 0;
   endfunction

   function automatic void model_step(logic dv, logic [7:0] d);
      int   ph;
      bit   ok;
      bit   e_err;
      obs_t e;
      e_err = 0;
      if (m_mode == 0) begin
         if (dv && d == W0) begin m_mode = 1; base = cyc; clean = 0; end
      end else begin
         ph = (cyc - base) % P;
         ok = slot_ok(ph, dv, d);
         if (m_mode == 1) begin
            if (!ok) m_mode = 0;
            else if (ph == P-1) begin
               clean++;
               if (clean == LOCKF) begin m_mode = 2; loss = 0; dirty = 0; end
            end
         end else begin
            if (!ok) begin
               e_err = 1;
               if (errs < (1 << CW) - 1) errs++;
               dirty = 1;
            end
            if (ph == P-1) begin
               if (!dirty) begin frames = (frames + 1) % (1 << CW); loss = 0; end
               else begin loss++; if (loss == LOSSF) m_mode = 0; end
               dirty = 0;
            end
         end
      end
      cyc++;
      e.locked = (m_mode == 2);
      e.err    = e_err;
      e.ec     = CW'(errs);
      e.fc     = CW'(frames);
      e.slot   = (m_mode == 0) ? 3'd0 : 3'((cyc - base) % P);
      exp_q.push_back(e);
   endfunction

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic step(input logic dv, input logic [7:0] d);
      @(negedge sclk);
      i_dv = dv;
      i_data = d;
      model_step(dv, d);
   endtask

   // bad_data: expected-word slots carry word+1; flip_dv: invert expected dv.
   task automatic frame(input logic [7:0] bad_data, input logic [7:0] flip_dv);
      for (int s = 0; s < P; s++) begin
         logic       dv;
         logic [7:0] d;
         dv = (s == 0) || (s == 2);
         d  = (s == 0) ? W0 : (s == 2) ? W2 : 8'($urandom);
         if (bad_data[s] && dv) d = d + 8'd1;
         if (flip_dv[s]) dv = !dv;
         step(dv, d);
      end
   endtask

   task automatic clean_frames(input int n);
      repeat (n) frame(8'h00, 8'h00);
   endtask

   task automatic settle();
      @(posedge sclk);
      #2;
   endtask

   initial begin : monitor
      forever begin
         obs_t e, a;
         @(posedge sclk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {o_locked, o_err, o_err_cnt, o_frame_cnt, o_slot};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL scoreboard t=%0t actual lock=%0b err=%0b ecnt=%0d fcnt=%0d slot=%0d required lock=%0b err=%0b ecnt=%0d fcnt=%0d slot=%0d",
                        $time, a.locked, a.err, a.ec, a.fc, a.slot,
                        e.locked, e.err, e.ec, e.fc, e.slot);
            end
         end
      end
   end

   initial begin : stim
      model_reset();
      #12;
      check("rst_locked", int'(o_locked), 0);
      check("rst_err", int'(o_err), 0);
      check("rst_err_cnt", int'(o_err_cnt), 0);
      check("rst_frame_cnt", int'(o_frame_cnt), 0);
      check("rst_slot", int'(o_slot), 0);
      @(negedge sclk);
      rst_n = 1'b1;

      // Noise in HUNT, including a W2 that must not be taken as slot 0.
      step(0, 8'h00); step(1, W2); step(1, 8'h33); step(0, 8'h07);

      clean_frames(2);
      settle();
      check("lock_at_t0_16", int'(o_locked), 1);
      clean_frames(3);
      settle();
      check("clean_frame_cnt", int'(o_frame_cnt), 3);
      check("clean_no_err", int'(o_err_cnt), 0);

      frame(8'b0000_0100, 8'h00);
      settle();
      check("wrong_data_err_cnt", int'(o_err_cnt), 1);
      check("wrong_data_locked", int'(o_locked), 1);
      check("wrong_data_frame_cnt", int'(o_frame_cnt), 3);
      clean_frames(1);

      frame(8'h00, 8'b0010_0000);
      frame(8'h00, 8'b0000_0001);
      settle();
      check("dv_fault_unlock", int'(o_locked), 0);
      check("dv_fault_err_cnt", int'(o_err_cnt), 3);

      frame(8'h00, 8'b0000_0010);
      settle();
      check("sync_abort_locked", int'(o_locked), 0);
      check("sync_abort_slot", int'(o_slot), 0);
      clean_frames(2);
      settle();
      check("relock_after_abort", int'(o_locked), 1);

      step(0, 8'h00);
      clean_frames(5);
      settle();
      check("relock_after_shift", int'(o_locked), 1);

      repeat (8) begin
         frame(8'b0000_0101, 8'b0001_0000);
         clean_frames(1);
      end
      settle();
      check("err_cnt_saturated", int'(o_err_cnt), 15);
      check("locked_during_sat", int'(o_locked), 1);

      // Sparse random faults and occasional phase slips.
      repeat (40) begin
         logic [7:0] bd, fd;
         bd = '0; fd = '0;
         for (int s = 0; s < P; s++) begin
            bd[s] = ($urandom_range(0, 15) == 0);
            fd[s] = ($urandom_range(0, 19) == 0);
         end
         if ($urandom_range(0, 9) == 0)
            repeat ($urandom_range(1, 3)) step(0, 8'($urandom));
         frame(bd, fd);
      end
      clean_frames(6);

      step(1, W0); step(0, 8'h00); step(1, W2);
      @(posedge sclk);
      #3;
      rst_n = 1'b0;
      i_dv = 1'b0;
      #1;
      check("midrst_locked", int'(o_locked), 0);
      check("midrst_err", int'(o_err), 0);
      check("midrst_err_cnt", int'(o_err_cnt), 0);
      check("midrst_frame_cnt", int'(o_frame_cnt), 0);
      check("midrst_slot", int'(o_slot), 0);
      model_reset();
      @(negedge sclk);
      rst_n = 1'b1;
      clean_frames(2);
      settle();
      check("lock_after_reset", int'(o_locked), 1);

      repeat (3) @(posedge sclk);
      #3;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ex_case_chk.md
Name: ex_case_chk

Overview:
- Receive-side checker for the 8-slot framed stream produced by the team's counter-driven pattern generator.
- Frame format: slot 0 carries a valid word 7, slot 1 is idle, slot 2 carries a valid word 5, slots 3..7 are idle.
- The block hunts for frame alignment, confirms it over several frames, then monitors the stream for violations.
- Reports lock status, per-sample error pulses, and saturating/wrapping statistics for a status register bank.

Parameters:
- PERIOD, 8: slots per frame; power of 2, 4..256. Slot counter width is SW = log2(PERIOD).
- W0, 8'd7: expected data in slot 0.
- W2, 8'd5: expected data in slot 2.
- LOCK_FRAMES, 2: consecutive clean frames needed to declare lock; range 1..15.
- LOSS_FRAMES, 2: consecutive errored frames while locked that cause loss of lock; range 1..15.
- CNT_W, 16: width of the statistic counters.

Ports:
- sclk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- i_dv  in  1  word valid from the generator.
- i_data  in  8  word data; ignored when i_dv=0.
- o_locked  out  1  registered; 1 while the FSM is in LOCKED.
- o_err  out  1  one-cycle registered pulse per mismatched sample while in LOCKED.
- o_err_cnt  out  CNT_W  mismatched samples counted in LOCKED; saturates at all-ones.
- o_frame_cnt  out  CNT_W  clean frames completed in LOCKED; wraps.
- o_slot  out  SW  current expected slot index; 0 in HUNT.

Behaviour:
- Reset (async assert, sync use after deassert): all outputs are 0, FSM=HUNT, slot=0, good/bad frame counters=0, frame_bad flag=0.
- Expected sample per slot:
  - slot 0: i_dv=1 and i_data=W0.
  - slot 2: i_dv=1 and i_data=W2.
  - any other slot: i_dv=0, with i_data don't-care.
- Any other combination in a slot is a mismatch. A mismatch includes a missing dv, an extra dv, or wrong data.
- Slot counter: in SYNC and LOCKED it advances by 1 every cycle and wraps from PERIOD-1 to 0.
- HUNT:
  - A cycle with i_dv=1 and i_data=W0 is taken as slot 0.
  - Next cycle: state=SYNC, slot=1, good=0, frame_bad=0.
  - No errors are counted in HUNT.
- SYNC:
  - Any mismatch sends the FSM to HUNT next cycle; good is cleared.
  - The mismatching cycle itself is not re-evaluated as a hunt candidate.
  - At slot PERIOD-1 with no mismatch in that frame, good is incremented. The partial frame whose slot 0 was found in HUNT counts as a frame.
  - If good+1 = LOCK_FRAMES, the next state is LOCKED and bad=0.
- LOCKED:
  - Each mismatch produces o_err=1 on the next cycle and increments o_err_cnt (saturating). It also sets frame_bad.
  - At slot PERIOD-1, frame_bad is evaluated including that cycle's sample:
    - Clean frame: o_frame_cnt increments and bad is cleared.
    - Errored frame: bad is incremented.
  - If the increment makes bad = LOSS_FRAMES, the next state is HUNT: o_locked=0 and slot=0 on the following cycle.
  - frame_bad clears at every frame end.
  - Alignment is never adjusted while locked; a shifted stream must cause loss of lock and re-hunt.
- Latency:
  - o_locked rises exactly one cycle after the slot PERIOD-1 sample of the LOCK_FRAMES-th clean frame.
  - o_err trails its sample by exactly 1 cycle.
- Statistics: o_err_cnt and o_frame_cnt are never cleared except by rst_n. They hold their values across loss of lock.
- Reset mid-operation: outputs return to reset values immediately (asynchronously); the next hunt starts after deassert.

Test Plan:
- Clean stream: reset, then the generator pattern from cycle t0 with the first W0 at t0. Required: o_locked=1 at t0+16, o_err never set, o_frame_cnt=3 after three further frames.
- Wrong data: with lock held, slot 2 carries 8'd6. Required: o_err pulses 1 cycle later, o_err_cnt=1, o_locked stays 1, and o_frame_cnt does not increment for that frame.
- Extra/missing dv: lock held; drive dv=1 in slot 5 of frame N and dv=0 in slot 0 of frame N+1. Required: two o_err pulses, o_err_cnt=2, bad=2, and o_locked=0 one cycle after slot 7 of frame N+1.
- SYNC abort: after the first W0, slot 1 has dv=1. Required: return to HUNT, o_locked stays 0; a clean stream afterward locks 16 cycles after its next W0.
- Shift: a locked stream is delayed by 1 cycle. Required: errors every frame, loss of lock after 2 frames, then relock 16 cycles after the first W0 seen in HUNT.
- Saturation and reset: with CNT_W=4, force 20 errors. Required: o_err_cnt=15. Asserting rst_n mid-frame clears all outputs immediately.
